// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-granular sharing of one uart_tx among
// NUM_REQ byte-stream requesters. Holds the grant until the owner's last byte
// has left the UART, and revokes it if the owner stalls mid-packet.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int GAP_TIMEOUT = 1024,
  parameter int BUSY_GUARD  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic [7:0]           tx_data,
  output logic                 tx_send,
  input  logic                 tx_busy,
  output logic                 timeout_err
);

  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GAPW = $clog2(GAP_TIMEOUT + 1);
  localparam int GRDW = $clog2(BUSY_GUARD + 1);
  localparam logic [GAPW-1:0] GAP_LAST = GAPW'(GAP_TIMEOUT - 1);
  localparam logic [GRDW-1:0] GRD_LAST = GRDW'(BUSY_GUARD - 1);
  localparam logic [IDXW-1:0] RR_INIT  = IDXW'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_t;

  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [IDXW-1:0]     gidx_q, gidx_d;
  logic [IDXW-1:0]     rr_q, rr_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_send_q, tx_send_d;
  logic                last_q, last_d;
  logic [GAPW-1:0]     gap_q, gap_d;
  logic [GRDW-1:0]     guard_q, guard_d;
  logic                timeout_q, timeout_d;

  logic                sel_valid, sel_last, hs;
  logic [7:0]          sel_data;
  logic                pick_found;
  logic [IDXW-1:0]     pick_idx, cidx;

  assign sel_valid = req_valid[gidx_q];
  assign sel_last  = req_last[gidx_q];
  assign sel_data  = req_data[8*gidx_q +: 8];
  assign hs        = (state_q == SEND) && sel_valid && !tx_busy;

  // Round-robin pick: first valid lane after the last served one.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cidx       = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cidx = IDXW'((32'(rr_q) + k) % NUM_REQ);
      if (!pick_found && req_valid[cidx]) begin
        pick_found = 1'b1;
        pick_idx   = cidx;
      end
    end
  end

  // Only the granted lane may see ready, and only while the UART is free.
  always_comb begin
    req_ready = '0;
    if (state_q == SEND && !tx_busy) req_ready = grant_q & req_valid;
  end

  // Next-state logic for the packet FSM and its counters.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    gidx_d    = gidx_q;
    rr_d      = rr_q;
    tx_data_d = tx_data_q;
    tx_send_d = 1'b0;
    last_d    = last_q;
    gap_d     = gap_q;
    guard_d   = guard_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          gidx_d            = pick_idx;
          gap_d             = '0;
          state_d           = SEND;
        end
      end
      SEND: begin
        if (hs) begin
          tx_data_d = sel_data;
          tx_send_d = 1'b1;
          last_d    = sel_last;
          gap_d     = '0;
          guard_d   = '0;
          state_d   = WAIT_HI;
        end else if (gap_q >= GAP_LAST) begin
          grant_d   = '0;
          timeout_d = 1'b1;
          rr_d      = gidx_q;
          gap_d     = '0;
          state_d   = IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      WAIT_HI: begin
        if (tx_busy || guard_q >= GRD_LAST) state_d = WAIT_LO;
        else                                guard_d = guard_q + 1'b1;
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          if (last_q) begin
            rr_d    = gidx_q;
            grant_d = '0;
            state_d = IDLE;
          end else begin
            state_d = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset drops any packet in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      gidx_q    <= '0;
      rr_q      <= RR_INIT;
      tx_data_q <= '0;
      tx_send_q <= 1'b0;
      last_q    <= 1'b0;
      gap_q     <= '0;
      guard_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      gidx_q    <= gidx_d;
      rr_q      <= rr_d;
      tx_data_q <= tx_data_d;
      tx_send_q <= tx_send_d;
      last_q    <= last_d;
      gap_q     <= gap_d;
      guard_q   <= guard_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant       = grant_q;
  assign tx_data     = tx_data_q;
  assign tx_send     = tx_send_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: packet-level reference model (round-robin owner
// choice, per-lane byte scoreboard, release/timeout rules) checked every cycle,
// directed scenarios with hand-computed timing, then randomized traffic.
module tb_uart_tx_arbiter;
  localparam int N  = 2;
  localparam int GT = 16;
  localparam int BG = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid, req_last, req_ready, grant;
  logic [8*N-1:0] req_data;
  logic [7:0]     tx_data;
  logic           tx_send, tx_busy, timeout_err;

  uart_tx_arbiter #(.NUM_REQ(N), .GAP_TIMEOUT(GT), .BUSY_GUARD(BG)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .grant(grant),
    .tx_data(tx_data), .tx_send(tx_send), .tx_busy(tx_busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  logic [8:0] lane_q [N][$];
  logic [7:0] exp_q  [N][$];
  int pause [N];
  logic [7:0] sent_q[$];
  int send_cyc[$], hs_cyc[$];
  logic [N-1:0] g_hist[$];
  int busy_len = 3, busy_cnt = 0;
  bit rand_mode = 0, model_en = 0, to_seen = 0;
  int to_cyc = 0, pushed = 0;
  int m_rr; bit m_done, p_hs, p_send;
  logic [N-1:0] p_grant, p_valid, l_grant;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int idx_of(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [N-1:0] rr_pick(input logic [N-1:0] v, input int rr);
    logic [N-1:0] r = '0;
    for (int k = 1; k <= N; k++) begin
      int i = (rr + k) % N;
      if (v[i]) begin r[i] = 1'b1; return r; end
    end
    return r;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      if (lane_q[i].size() > 0 && pause[i] == 0) begin
        logic [8:0] e = lane_q[i][0];
        req_valid[i]        = 1'b1;
        req_data[8*i +: 8]  = e[7:0];
        req_last[i]         = e[8];
      end else begin
        req_valid[i]        = 1'b0;
        req_data[8*i +: 8]  = 8'($urandom);
        req_last[i]         = 1'($urandom);
      end
    end
  endtask

  task automatic push_byte(input int lane, input logic [7:0] d, input bit last);
    lane_q[lane].push_back({last, d});
    exp_q[lane].push_back(d);
    pushed++;
  endtask

  task automatic model_reset();
    m_rr = N - 1; m_done = 0; p_hs = 0; p_send = 0;
    p_grant = '0; p_valid = '0;
  endtask

  task automatic clear_log();
    sent_q.delete(); send_cyc.delete(); hs_cyc.delete(); to_seen = 0;
  endtask

  // One clock: sample at negedge, check against the model, drive after posedge.
  task automatic step();
    logic [N-1:0] s_valid, s_ready, s_grant, s_last, hs;
    logic s_send, s_busy, s_to;
    logic [7:0] s_data;
    int g;
    @(negedge clk);
    s_valid = req_valid; s_ready = req_ready; s_grant = grant; s_last = req_last;
    s_send = tx_send; s_busy = tx_busy; s_to = timeout_err; s_data = tx_data;
    hs = s_valid & s_ready;
    g_hist.push_back(s_grant);
    l_grant = s_grant;
    if (model_en) begin
      chk("grant_onehot", 32'($onehot0(s_grant)), 1);
      chk("ready_granted", 32'(s_ready & ~(s_grant & s_valid)), 0);
      if (s_ready != 0) chk("ready_busy", 32'(s_busy), 0);
      chk("send_after_hs", 32'(s_send), 32'(p_hs));
      if (s_send) begin
        chk("send_consecutive", 32'(p_send), 0);
        chk("send_busy", 32'(s_busy), 0);
        g = idx_of(s_grant);
        if (g >= 0 && exp_q[g].size() > 0) chk("tx_data", 32'(s_data), 32'(exp_q[g].pop_front()));
        else chk("send_owner", 32'(g >= 0), 2);
        sent_q.push_back(s_data);
        send_cyc.push_back(cyc);
      end
      if (hs != 0) begin
        chk("hs_after_last", 32'(m_done), 0);
        m_done = ((hs & s_last) != 0);
        hs_cyc.push_back(cyc);
      end
      if (p_grant == 0) begin
        chk("arb_grant", 32'(s_grant), 32'(rr_pick(p_valid, m_rr)));
      end else if (s_grant == 0) begin
        chk("release_cause", 32'(s_to), 32'(!m_done));
        m_rr = idx_of(p_grant);
        m_done = 0;
      end else begin
        chk("grant_stable", 32'(s_grant), 32'(p_grant));
      end
      if (!(p_grant != 0 && s_grant == 0)) chk("timeout_spurious", 32'(s_to), 0);
      if (s_to) begin to_seen = 1; to_cyc = cyc; end
      p_grant = s_grant; p_valid = s_valid; p_hs = (hs != 0); p_send = s_send;
    end
    cyc++;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        lane_q[i].delete(0);
        pause[i] = rand_mode ? int'($urandom_range(0, 3)) : 0;
      end else if (pause[i] > 0) pause[i]--;
    end
    if (s_send) begin
      int l = rand_mode ? int'($urandom_range(0, 5)) : busy_len;
      if (l > 0) begin tx_busy = 1'b1; busy_cnt = l; end
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) tx_busy = 1'b0;
    end
    drive_inputs();
  endtask

  task automatic run_until_idle(input int max, input string name);
    int n = 0;
    bit done = 0;
    while (!done && n < max) begin
      step();
      n++;
      done = (l_grant == 0) && (tx_busy == 0);
      for (int i = 0; i < N; i++) if (lane_q[i].size() != 0) done = 0;
    end
    chk({name, "_drain"}, 32'(done), 1);
  endtask

  function automatic logic [31:0] sent_at(input int k);
    return (k < sent_q.size()) ? 32'(sent_q[k]) : 32'hFFFF_FFFF;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, nb, t;
    for (int i = 0; i < N; i++) pause[i] = 0;
    tx_busy = 1'b0;
    rst_n = 1'b0;
    drive_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_send", 32'(tx_send), 0);
    chk("rst_data", 32'(tx_data), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_timeout", 32'(timeout_err), 0);
    rst_n = 1'b1;
    model_reset();
    model_en = 1;

    // Ties: lane 0 first after reset, then alternation follows last-served lane.
    clear_log(); busy_len = 2;
    push_byte(0, 8'h10, 1); push_byte(1, 8'h20, 1); drive_inputs();
    run_until_idle(200, "tie1");
    chk("tie1_first", sent_at(0), 8'h10); chk("tie1_second", sent_at(1), 8'h20);
    clear_log();
    push_byte(0, 8'h11, 1); push_byte(1, 8'h21, 1); drive_inputs();
    run_until_idle(200, "tie2");
    chk("tie2_first", sent_at(0), 8'h11); chk("tie2_second", sent_at(1), 8'h21);
    clear_log();
    push_byte(0, 8'h30, 1); drive_inputs();
    run_until_idle(200, "solo0");
    push_byte(0, 8'h12, 1); push_byte(1, 8'h22, 1); drive_inputs();
    run_until_idle(200, "tie3");
    chk("tie3_solo", sent_at(0), 8'h30);
    chk("tie3_first", sent_at(1), 8'h22); chk("tie3_second", sent_at(2), 8'h12);

    // Three-byte packet with a 3-cycle busy UART: sends at +2, +8, +14, release at +19.
    clear_log(); busy_len = 3; base = cyc;
    push_byte(0, 8'hA1, 0); push_byte(0, 8'hA2, 0); push_byte(0, 8'hA3, 1); drive_inputs();
    run_until_idle(200, "pkt3");
    chk("pkt3_count", 32'(send_cyc.size()), 3);
    if (send_cyc.size() == 3) begin
      chk("pkt3_t0", 32'(send_cyc[0] - base), 2);
      chk("pkt3_t1", 32'(send_cyc[1] - base), 8);
      chk("pkt3_t2", 32'(send_cyc[2] - base), 14);
    end
    chk("pkt3_b0", sent_at(0), 8'hA1); chk("pkt3_b1", sent_at(1), 8'hA2); chk("pkt3_b2", sent_at(2), 8'hA3);
    nb = 0;
    for (int c = base + 1; c <= base + 18; c++) if (g_hist[c] !== 2'b01) nb++;
    chk("pkt3_grant_held", 32'(nb), 0);
    chk("pkt3_grant_released", 32'(g_hist[base + 19]), 0);

    // Lane 1 mid-packet keeps the grant while lane 0 waits.
    clear_log();
    push_byte(1, 8'h55, 0); push_byte(1, 8'h56, 1); drive_inputs();
    nb = 0;
    while (sent_q.size() == 0 && nb < 100) begin step(); nb++; end
    chk("mid_first_send_seen", 32'(sent_q.size() > 0), 1);
    push_byte(0, 8'h77, 1); drive_inputs();
    run_until_idle(200, "mid");
    chk("mid_b0", sent_at(0), 8'h55); chk("mid_b1", sent_at(1), 8'h56); chk("mid_b2", sent_at(2), 8'h77);

    // Gap timeout with a UART that never raises busy: revoke 4+2+16 cycles after the handshake.
    clear_log(); busy_len = 0;
    push_byte(0, 8'h40, 0); drive_inputs();
    nb = 0;
    while (hs_cyc.size() == 0 && nb < 100) begin step(); nb++; end
    chk("to_hs_seen", 32'(hs_cyc.size() > 0), 1);
    t = (hs_cyc.size() > 0) ? hs_cyc[0] : 0;
    push_byte(1, 8'h41, 1); drive_inputs();
    nb = 0;
    while (!to_seen && nb < 200) begin step(); nb++; end
    chk("to_seen", 32'(to_seen), 1);
    chk("to_latency", 32'(to_cyc - t), 22);
    run_until_idle(200, "to");
    if (to_seen) begin
      chk("to_grant_zero", 32'(g_hist[to_cyc]), 0);
      chk("to_next_lane1", 32'(g_hist[to_cyc + 1]), 2'b10);
    end
    chk("to_b0", sent_at(0), 8'h40); chk("to_b1", sent_at(1), 8'h41);

    // Busy never rises: the guard paces back-to-back bytes 6 cycles apart.
    clear_log(); busy_len = 0;
    push_byte(0, 8'h50, 0); push_byte(0, 8'h51, 1); drive_inputs();
    run_until_idle(200, "guard");
    chk("guard_count", 32'(send_cyc.size()), 2);
    if (send_cyc.size() == 2) chk("guard_spacing", 32'(send_cyc[1] - send_cyc[0]), 6);

    // Reset while waiting for busy to fall in a two-byte packet.
    clear_log(); busy_len = 3;
    push_byte(0, 8'hB1, 0); push_byte(0, 8'hB2, 1); drive_inputs();
    nb = 0;
    while (sent_q.size() == 0 && nb < 100) begin step(); nb++; end
    step(); step();
    #2;
    rst_n = 1'b0;
    model_en = 0;
    #1;
    chk("mrst_grant", 32'(grant), 0);
    chk("mrst_send", 32'(tx_send), 0);
    chk("mrst_data", 32'(tx_data), 0);
    chk("mrst_ready", 32'(req_ready), 0);
    chk("mrst_timeout", 32'(timeout_err), 0);
    for (int i = 0; i < N; i++) begin lane_q[i].delete(); exp_q[i].delete(); pause[i] = 0; end
    tx_busy = 1'b0; busy_cnt = 0;
    drive_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset(); model_en = 1; clear_log();
    base = cyc;
    push_byte(0, 8'hC1, 1); drive_inputs();
    run_until_idle(200, "post_rst");
    chk("post_rst_grant", 32'(g_hist[base + 1]), 2'b01);
    chk("post_rst_b0", sent_at(0), 8'hC1);
    chk("post_rst_count", 32'(sent_q.size()), 1);

    // Randomized traffic against the model.
    clear_log(); rand_mode = 1; pushed = 0;
    for (int it = 0; it < 4000; it++) begin
      if ($urandom_range(0, 15) == 0) begin
        int lane = int'($urandom_range(0, N - 1));
        int len  = int'($urandom_range(1, 4));
        for (int b = 0; b < len; b++) push_byte(lane, 8'($urandom), b == len - 1);
      end
      step();
    end
    run_until_idle(3000, "rand");
    chk("rand_sent_all", 32'(sent_q.size()), 32'(pushed));
    nb = 0;
    for (int i = 0; i < N; i++) nb += exp_q[i].size();
    chk("rand_scoreboard_empty", 32'(nb), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
